// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the 5-stage core pipeline registers:
//                control-bundle field offsets, per-boundary data widths and
//                a small occupancy helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Control bundle bit positions as used by the core
  localparam int CTRL_WREG     = 0;
  localparam int CTRL_M2REG    = 1;
  localparam int CTRL_WMEM     = 2;
  localparam int CTRL_ALUC_LSB = 3;
  localparam int CTRL_ALUC_MSB = 6;
  localparam int CTRL_ALUIMM   = 7;
  localparam int CTRL_REGRT    = 8;
  localparam int CORE_CTRL_W   = 9;

  // Data bundle width at each stage boundary of the core
  localparam int DATA_W_IFID   = 32;
  localparam int DATA_W_IDEXE  = 101;
  localparam int DATA_W_EXEMEM = 69;
  localparam int DATA_W_MEMWB  = 69;

  // Number of held entries from the two valid bits (0..2)
  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_entry_reg
//  Description : One pipeline entry: valid bit plus control and data bundles.
//                clear_i drops the valid bit (bundles keep their value),
//                load_i captures a new entry. clear_i wins over load_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_entry_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next entry: hold by default, clear kills valid only, load takes new bundles
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  // Entry storage with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Handshaked pipeline-stage register with optional 2-entry skid
//                buffer, synchronous flush (bubble insertion) and a saturating
//                stall counter. Main entry M drives the outputs; skid entry S
//                only fills when M is stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  input  logic              clr_cnt_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        occupancy_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl;
  logic [DATA_W-1:0] m_data,  s_data;

  logic              in_ready;
  logic              push, pop;
  logic              m_load, m_clear, m_from_s;
  logic              s_load, s_clear;
  logic              m_valid_nx, s_valid_nx;
  logic [CTRL_W-1:0] m_ctrl_in;
  logic [DATA_W-1:0] m_data_in;

  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign push = in_valid_i & in_ready;
  assign pop  = m_valid & out_ready_i;

  // Entry movement: flush kills everything, S refills M on pop, push goes to
  // whichever entry is next free in FIFO order
  always_comb begin
    m_load   = 1'b0;
    m_clear  = 1'b0;
    m_from_s = 1'b0;
    s_load   = 1'b0;
    s_clear  = 1'b0;
    if (flush_i) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (pop) begin
      if (s_valid) begin
        m_load   = 1'b1;
        m_from_s = 1'b1;
        if (push) s_load  = 1'b1;
        else      s_clear = 1'b1;
      end else if (push) begin
        m_load = 1'b1;
      end else begin
        m_clear = 1'b1;
      end
    end else if (push) begin
      if (m_valid) s_load = 1'b1;
      else         m_load = 1'b1;
    end
  end

  assign m_ctrl_in = m_from_s ? s_ctrl : in_ctrl_i;
  assign m_data_in = m_from_s ? s_data : in_data_i;

  // Post-edge valid bits, used for the registered occupancy and in_ready
  assign m_valid_nx = m_clear ? 1'b0 : (m_load | m_valid);
  assign s_valid_nx = (SKID != 0) && !s_clear && (s_load | s_valid);

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (m_clear),
    .load_i  (m_load),
    .ctrl_i  (m_ctrl_in),
    .data_i  (m_data_in),
    .valid_o (m_valid),
    .ctrl_o  (m_ctrl),
    .data_o  (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (s_clear),
        .load_i  (s_load),
        .ctrl_i  (in_ctrl_i),
        .data_i  (in_data_i),
        .valid_o (s_valid),
        .ctrl_o  (s_ctrl),
        .data_o  (s_data)
      );

      // Registered ready: accept whenever the skid entry will be empty
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= !s_valid_nx;
      end

      assign in_ready = rdy_q;
    end else begin : g_no_skid
      assign s_valid  = 1'b0;
      assign s_ctrl   = '0;
      assign s_data   = '0;
      assign in_ready = !m_valid | out_ready_i;
    end
  endgenerate

  // Stall counter next value: clear first, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (m_valid && !out_ready_i && !flush_i && cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign occ_d = occ_count(m_valid_nx, s_valid_nx);

  // Counter and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      occ_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
      occ_q <= occ_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = m_valid;
  assign out_ctrl_o  = m_valid ? m_ctrl : '0;
  assign out_data_o  = m_data;
  assign stall_cnt_o = cnt_q;
  assign occupancy_o = occ_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg. Drives one SKID=1 and
//                one SKID=0 instance from the same stimulus and checks both
//                against a FIFO-level reference model every cycle, plus
//                literal expectations for the directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl  = '0;
  logic [31:0] in_data  = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;

  logic [1:0]        a_vld, a_rdy;
  logic [1:0][7:0]   a_ctrl;
  logic [1:0][31:0]  a_data;
  logic [1:0][1:0]   a_occ;
  logic [1:0][3:0]   a_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per instance a FIFO of up to 2 entries (1 when no skid)
  ent_t        me [2][2];
  int          mn [2];
  logic [3:0]  mc [2];
  logic [31:0] mh [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_dut_skid (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(a_rdy[0]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(a_vld[0]), .out_ready_i(out_ready), .out_ctrl_o(a_ctrl[0]), .out_data_o(a_data[0]),
    .flush_i(flush), .clr_cnt_i(clr_cnt), .stall_cnt_o(a_cnt[0]), .occupancy_o(a_occ[0])
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_dut_noskid (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(a_rdy[1]), .in_ctrl_i(in_ctrl), .in_data_i(in_data),
    .out_valid_o(a_vld[1]), .out_ready_i(out_ready), .out_ctrl_o(a_ctrl[1]), .out_data_o(a_data[1]),
    .flush_i(flush), .clr_cnt_i(clr_cnt), .stall_cnt_o(a_cnt[1]), .occupancy_o(a_occ[1])
  );

  function automatic logic mdl_ready(input int k);
    if (k == 0) return mn[k] < 2;
    return (mn[k] == 0) || out_ready;
  endfunction

  // Model state update at each edge (async reset mirrors the DUT)
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      logic psh, pp;
      if (!rst_n) begin
        mn[k] = 0;
        mc[k] = '0;
        mh[k] = '0;
      end else begin
        psh = in_valid && mdl_ready(k);
        pp  = (mn[k] > 0) && out_ready;
        if (clr_cnt) mc[k] = '0;
        else if (mn[k] > 0 && !out_ready && !flush && mc[k] != 4'hf) mc[k] = mc[k] + 4'd1;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (pp) begin
            me[k][0] = me[k][1];
            mn[k] = mn[k] - 1;
          end
          if (psh) begin
            me[k][mn[k]] = '{c: in_ctrl, d: in_data};
            mn[k] = mn[k] + 1;
          end
        end
        if (mn[k] > 0) mh[k] = me[k][0].d;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic ev;
      ev = mn[k] > 0;
      chk($sformatf("d%0d.out_valid", k), 64'(a_vld[k]), 64'(ev));
      chk($sformatf("d%0d.out_ctrl", k),  64'(a_ctrl[k]), ev ? 64'(me[k][0].c) : 64'd0);
      chk($sformatf("d%0d.out_data", k),  64'(a_data[k]), ev ? 64'(me[k][0].d) : 64'(mh[k]));
      chk($sformatf("d%0d.in_ready", k),  64'(a_rdy[k]), 64'(mdl_ready(k)));
      chk($sformatf("d%0d.occupancy", k), 64'(a_occ[k]), 64'(mn[k]));
      chk($sformatf("d%0d.stall_cnt", k), 64'(a_cnt[k]), 64'(mc[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] c, input logic [31:0] d, input logic ordy);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    chk("reset.out_valid", 64'(a_vld[0]), 64'd0);
    chk("reset.out_data",  64'(a_data[0]), 64'd0);
    chk("reset.in_ready",  64'(a_rdy[0]), 64'd1);
    chk("reset.occupancy", 64'(a_occ[0]), 64'd0);
    rst_n = 1'b1;
    step();

    // 1: streaming with out_ready=1
    drv(1'b1, 8'h11, 32'h8c220000, 1'b1); step();
    chk("t1.data0", 64'(a_data[0]), 64'h8c220000);
    chk("t1.rdy0",  64'(a_rdy[0]), 64'd1);
    drv(1'b1, 8'h12, 32'h8c230004, 1'b1); step();
    chk("t1.data1", 64'(a_data[0]), 64'h8c230004);
    drv(1'b1, 8'h13, 32'h8c240008, 1'b1); step();
    chk("t1.data2", 64'(a_data[0]), 64'h8c240008);
    chk("t1.ctrl2", 64'(a_ctrl[0]), 64'h13);
    drv(1'b0, 8'h00, 32'h0, 1'b1); step();
    chk("t1.drained", 64'(a_vld[0]), 64'd0);
    chk("t1.stall",   64'(a_cnt[0]), 64'd0);

    // 2: backpressure, A held while B goes to the skid entry
    drv(1'b1, 8'h21, 32'h0000000a, 1'b1); step();
    drv(1'b1, 8'h22, 32'h0000000b, 1'b0); step();
    drv(1'b0, 8'h00, 32'h0, 1'b0); step(); step();
    chk("t2.occ",   64'(a_occ[0]), 64'd2);
    chk("t2.rdy",   64'(a_rdy[0]), 64'd0);
    chk("t2.stall", 64'(a_cnt[0]), 64'd3);
    chk("t2.headA", 64'(a_data[0]), 64'ha);
    out_ready = 1'b1; step();
    chk("t2.headB", 64'(a_data[0]), 64'hb);
    chk("t2.ctrlB", 64'(a_ctrl[0]), 64'h22);
    step();
    chk("t2.empty", 64'(a_vld[0]), 64'd0);

    // 3: flush with two entries held and C offered
    drv(1'b1, 8'h31, 32'h00000031, 1'b0); step();
    drv(1'b1, 8'h32, 32'h00000032, 1'b0); step();
    drv(1'b1, 8'h3c, 32'h0000003c, 1'b0); flush = 1'b1; step();
    flush = 1'b0;
    chk("t3.valid", 64'(a_vld[0]), 64'd0);
    chk("t3.ctrl",  64'(a_ctrl[0]), 64'd0);
    chk("t3.occ",   64'(a_occ[0]), 64'd0);
    chk("t3.rdy",   64'(a_rdy[0]), 64'd1);
    chk("t3.stall", 64'(a_cnt[0]), 64'd4);
    // flush with an accepted push: the pushed entry is discarded
    drv(1'b1, 8'h3d, 32'h0000003d, 1'b0); step();
    drv(1'b1, 8'h3e, 32'h0000003e, 1'b1); flush = 1'b1; step();
    flush = 1'b0;
    drv(1'b0, 8'h00, 32'h0, 1'b1); step();
    chk("t3.no_c", 64'(a_vld[0]), 64'd0);

    // 4: asynchronous reset between edges
    drv(1'b1, 8'h41, 32'h00000041, 1'b1); step();
    #2 rst_n = 1'b0;
    #1;
    chk("t4.rst_valid", 64'(a_vld[0]), 64'd0);
    chk("t4.rst_data",  64'(a_data[0]), 64'd0);
    chk("t4.rst_occ",   64'(a_occ[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drv(1'b1, 8'h4f, 32'h0000004f, 1'b1); step();
    chk("t4.first_valid", 64'(a_vld[0]), 64'd1);
    chk("t4.first_data",  64'(a_data[0]), 64'h4f);

    // 5: stall counter saturation and clear
    drv(1'b0, 8'h00, 32'h0, 1'b0); clr_cnt = 1'b1; step();
    clr_cnt = 1'b0;
    repeat (20) step();
    chk("t5.sat", 64'(a_cnt[0]), 64'd15);
    clr_cnt = 1'b1; step();
    clr_cnt = 1'b0;
    chk("t5.clr", 64'(a_cnt[0]), 64'd0);

    // 6: no-skid instance, M full
    chk("t6.rdy_stalled", 64'(a_rdy[1]), 64'd0);
    chk("t6.occ_stalled", 64'(a_occ[1]), 64'd1);
    drv(1'b1, 8'h61, 32'h00000061, 1'b1);
    #1;
    chk("t6.rdy_comb", 64'(a_rdy[1]), 64'd1);
    step();
    chk("t6.replaced", 64'(a_data[1]), 64'h61);
    chk("t6.occ_one",  64'(a_occ[1]), 64'd1);

    // Mixed traffic pattern, checked by the model only
    for (int i = 0; i < 40; i++) begin
      drv((i % 4) != 3, 8'(8'h80 + i), 32'hd0000000 + 32'(i), (i % 3) != 0);
      flush   = (i == 17) || (i == 30);
      clr_cnt = (i == 25);
      step();
    end
    drv(1'b0, 8'h00, 32'h0, 1'b1);
    flush = 1'b0;
    clr_cnt = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg
`default_nettype wire
